fib_sram_arb: RTL

//  Round-robin arbiter sharing the single FIB SRAM read port among NREQ lookup engines
//  (one per ingress interface). Serialises address issue, tracks outstanding reads
//  in an in-order tag FIFO, and routes each returned word to the engine that issued it.

---
 rtl/fib_sram_arb_if.sv | 28 ++
 rtl/fib_sram_arb.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fib_sram_arb_if.sv
// Bundle of requester-side and SRAM-side signals for the FIB SRAM read-port arbiter.
// master: the arbiter itself; slave: the lookup engines plus SRAM it talks to.
interface fib_sram_arb_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 36
);
    logic [NREQ-1:0]        c_req;
    logic [NREQ*ADDR_W-1:0] c_addr;
    logic [NREQ-1:0]        c_ack;
    logic [NREQ-1:0]        c_vld;
    logic [DATA_W-1:0]      c_data;
    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_ack;
    logic                   rd_vld;
    logic [DATA_W-1:0]      rd_data;

    modport master (
        input  c_req, c_addr, rd_ack, rd_vld, rd_data,
        output c_ack, c_vld, c_data, rd_req, rd_addr
    );

    modport slave (
        output c_req, c_addr, rd_ack, rd_vld, rd_data,
        input  c_ack, c_vld, c_data, rd_req, rd_addr
    );
endinterface

// File: rtl/fib_sram_arb.sv
// Round-robin arbiter sharing one FIB SRAM read port among NREQ lookup engines;
// an in-order tag FIFO steers each returned word back to the engine that issued it.
module fib_sram_arb #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 36,
    parameter int MAX_OUT = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    fib_sram_arb_if.master    bus,
    output logic              busy,
    output logic              err_vld
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant, grant, grant_sel, head;
    logic            grant_found;
    logic [NREQ-1:0] eligible;
    logic            do_grant, ack_now;
    logic            fifo_empty, pop, push, bypass;
    logic [GW-1:0]   tag_mem [MAX_OUT];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    // Scan downward so the requester closest after last_grant is the final (winning) hit.
    always_comb begin
        eligible    = bus.c_req & ~bus.c_ack;
        grant_found = 1'b0;
        grant_sel   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (eligible[(int'(last_grant) + i) % NREQ]) begin
                grant_found = 1'b1;
                grant_sel   = GW'((int'(last_grant) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        ack_now   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && (count < CW'(MAX_OUT))) begin
                    do_grant  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.rd_ack) begin
                    ack_now   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A word arriving with the FIFO empty can only belong to the read being acked right now.
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];
    assign pop        = bus.rd_vld & ~fifo_empty;
    assign bypass     = bus.rd_vld & fifo_empty & ack_now;
    assign push       = ack_now & ~bypass;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.rd_req  <= 1'b0;
            bus.rd_addr <= '0;
            bus.c_ack   <= '0;
            bus.c_vld   <= '0;
            bus.c_data  <= '0;
            err_vld     <= 1'b0;
            grant       <= '0;
            last_grant  <= GW'(NREQ - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            bus.c_ack <= '0;
            bus.c_vld <= '0;
            if (do_grant) begin
                bus.rd_req  <= 1'b1;
                bus.rd_addr <= bus.c_addr[int'(grant_sel)*ADDR_W +: ADDR_W];
                grant       <= grant_sel;
            end else if (ack_now) begin
                bus.rd_req <= 1'b0;
            end
            if (ack_now) begin
                bus.c_ack[grant] <= 1'b1;
                last_grant       <= grant;
            end
            if (pop) begin
                bus.c_vld[head] <= 1'b1;
                bus.c_data      <= bus.rd_data;
                rd_ptr          <= rd_ptr + PW'(1);
            end else if (bypass) begin
                bus.c_vld[grant] <= 1'b1;
                bus.c_data       <= bus.rd_data;
            end
            if (bus.rd_vld && fifo_empty && !ack_now) err_vld <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end
endmodule
